// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing, frame size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver/transmitter state encoding, shared by both directions
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  // 50 MHz core clock / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

  // Data bits carried in one frame
  localparam int FRAME_DATA_BITS = 8;

  // Width of the per-bit cycle counter
  localparam int CLK_CNT_W = 9;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-level output channel of the UART receiver plus its status pulses.
// Latency: n/a (wires only).
// Backpressure: consumer drives rx_ready; a byte moves when rx_valid && rx_ready.
interface uart_rx_if;
  import uart_pkg::*;

  logic [FRAME_DATA_BITS-1:0] rx_data;
  logic                       rx_valid;
  logic                       rx_ready;
  logic                       rx_frame_err;
  logic                       rx_overrun;
  logic                       rx_busy;

  // Receiver side: produces bytes and status
  modport master (
    output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
    input  rx_ready
  );

  // Consumer side: takes bytes and watches status
  modport slave (
    input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the rx_clk domain.
// Latency: 2 rx_clk cycles.
// Backpressure: none; the input is sampled every cycle.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic rx_clk,
  input  logic rx_rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  // Shift the async level through two flops; both reset to the idle level
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      meta_q   <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, one-byte holding register.
// Latency: byte presented the cycle after the stop bit is sampled (mid stop bit + 2-cycle sync).
// Backpressure: none on the line; a byte completing while one is still held is dropped and flagged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = FRAME_DATA_BITS
) (
  input  logic       rx_clk,
  input  logic       rx_rst_n,
  input  logic       rx_input,
  uart_rx_if.master  rx_if
);

  localparam logic [CLK_CNT_W-1:0] HALF_CNT = CLK_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CLK_CNT_W-1:0] FULL_CNT = CLK_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]           LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CLK_CNT_W-1:0] clk_count;
  logic [2:0]           bit_idx;
  logic [7:0]           shift_reg;
  logic                 rx_sync;
  logic                 byte_done;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .async_in (rx_input),
    .sync_out (rx_sync)
  );

  // A good stop bit at its sample point completes the byte in shift_reg
  assign byte_done = (state == ST_STOP) && (clk_count == FULL_CNT) && rx_sync;

  // Frame FSM: start detect, mid-bit sampling, stop check, break hold-off
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state              <= ST_IDLE;
      clk_count          <= '0;
      bit_idx            <= '0;
      shift_reg          <= '0;
      rx_if.rx_frame_err <= 1'b0;
      rx_if.rx_busy      <= 1'b0;
    end else begin
      rx_if.rx_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_count <= '0;
          bit_idx   <= '0;
          if (!rx_sync) begin
            state         <= ST_START;
            rx_if.rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_count == HALF_CNT) begin
            clk_count <= '0;
            bit_idx   <= '0;
            if (!rx_sync) begin
              state <= ST_DATA;
            end else begin
              // Line went back high before mid start bit: treat as noise
              state         <= ST_IDLE;
              rx_if.rx_busy <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        ST_DATA: begin
          if (clk_count == FULL_CNT) begin
            clk_count          <= '0;
            shift_reg[bit_idx] <= rx_sync;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        ST_STOP: begin
          if (clk_count == FULL_CNT) begin
            clk_count <= '0;
            if (rx_sync) begin
              state         <= ST_IDLE;
              rx_if.rx_busy <= 1'b0;
            end else begin
              // Bad stop bit: drop the byte and wait out the low line
              rx_if.rx_frame_err <= 1'b1;
              shift_reg          <= '0;
              state              <= ST_BREAK;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end
        ST_BREAK: begin
          clk_count <= '0;
          if (rx_sync) begin
            state         <= ST_IDLE;
            rx_if.rx_busy <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          clk_count     <= '0;
          bit_idx       <= '0;
          rx_if.rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load on completion if empty or draining, else flag overrun
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      rx_if.rx_data    <= '0;
      rx_if.rx_valid   <= 1'b0;
      rx_if.rx_overrun <= 1'b0;
    end else begin
      rx_if.rx_overrun <= 1'b0;
      if (byte_done && (!rx_if.rx_valid || rx_if.rx_ready)) begin
        rx_if.rx_data  <= shift_reg;
        rx_if.rx_valid <= 1'b1;
      end else begin
        if (byte_done) begin
          rx_if.rx_overrun <= 1'b1;
        end
        if (rx_if.rx_valid && rx_if.rx_ready) begin
          rx_if.rx_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames in, byte channel and status pulses out.
// Latency: n/a (testbench).
// Backpressure: bench drives rx_ready to exercise hold and overrun behaviour.
module tb_uart_rx;

  localparam int BIT_T = 434;

  logic rx_clk = 1'b0;
  logic rx_rst_n;
  logic rx_input;

  int checks   = 0;
  int failures = 0;

  // Monitor tallies, only ever written by the monitor process
  int         vld_cycles = 0;
  int         err_cycles = 0;
  int         ovr_cycles = 0;
  logic [7:0] got_q[$];

  // Reference model: bytes the consumer is expected to receive, in order
  logic [7:0] exp_q[$];

  always #5 rx_clk = ~rx_clk;

  uart_rx_if u_if ();

  uart_rx #(
    .CLKS_PER_BIT (BIT_T),
    .DATA_BITS    (8)
  ) dut (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .rx_input (rx_input),
    .rx_if    (u_if)
  );

  // Observe the consumer side between rising edges
  always @(negedge rx_clk) begin
    if (rx_rst_n) begin
      if (u_if.rx_valid) vld_cycles = vld_cycles + 1;
      if (u_if.rx_frame_err) err_cycles = err_cycles + 1;
      if (u_if.rx_overrun) ovr_cycles = ovr_cycles + 1;
      if (u_if.rx_valid && u_if.rx_ready) got_q.push_back(u_if.rx_data);
    end
  end

  // Hard stop in case a task never returns
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge rx_clk);
    #1;
  endtask

  // One 8N1 frame, LSB first; the line is left at the stop level afterwards
  task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
    rx_input = 1'b0;
    tick(period);
    for (int i = 0; i < 8; i++) begin
      rx_input = b[i];
      tick(period);
    end
    rx_input = stop_bit;
    tick(period);
  endtask

  task automatic test_reset;
    rx_rst_n = 1'b0;
    rx_input = 1'b1;
    u_if.rx_ready = 1'b1;
    tick(3);
    checks++; if (u_if.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", u_if.rx_data); end
    checks++; if (u_if.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", u_if.rx_valid); end
    checks++; if (u_if.rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", u_if.rx_frame_err); end
    checks++; if (u_if.rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b want 0", u_if.rx_overrun); end
    checks++; if (u_if.rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", u_if.rx_busy); end
    rx_rst_n = 1'b1;
    tick(50);
    checks++; if (u_if.rx_busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", u_if.rx_busy); end
  endtask

  task automatic test_single;
    int g0 = got_q.size();
    int v0 = vld_cycles;
    int e0 = err_cycles;
    int o0 = ovr_cycles;
    u_if.rx_ready = 1'b1;
    send_frame(8'h54, BIT_T, 1'b1);
    tick(20);
    checks++; if (got_q.size() - g0 !== 1) begin failures++; $display("FAIL single_count: got %0d want 1", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== 8'h54) begin failures++; $display("FAIL single_data: got %h want 54", got_q[g0]); end
    end
    checks++; if (vld_cycles - v0 !== 1) begin failures++; $display("FAIL single_vld_width: got %0d want 1", vld_cycles - v0); end
    checks++; if (err_cycles - e0 !== 0) begin failures++; $display("FAIL single_ferr: got %0d want 0", err_cycles - e0); end
    checks++; if (ovr_cycles - o0 !== 0) begin failures++; $display("FAIL single_ovr: got %0d want 0", ovr_cycles - o0); end
    checks++; if (u_if.rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b want 0", u_if.rx_busy); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] frames[4] = '{8'h51, 8'h52, 8'h53, 8'h54};
    int g0 = got_q.size();
    int o0 = ovr_cycles;
    // Model: with the consumer stalled, the first byte is held and every later one is lost
    logic [7:0] exp_held = frames[0];
    int exp_ovr = $size(frames) - 1;
    u_if.rx_ready = 1'b0;
    foreach (frames[i]) begin
      send_frame(frames[i], BIT_T, 1'b1);
      checks++; if (u_if.rx_data !== exp_held) begin failures++; $display("FAIL b2b_hold%0d: got %h want %h", i, u_if.rx_data, exp_held); end
    end
    tick(20);
    checks++; if (u_if.rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b want 1", u_if.rx_valid); end
    checks++; if (ovr_cycles - o0 !== exp_ovr) begin failures++; $display("FAIL b2b_ovr: got %0d want %0d", ovr_cycles - o0, exp_ovr); end
    checks++; if (got_q.size() - g0 !== 0) begin failures++; $display("FAIL b2b_stall: got %0d want 0", got_q.size() - g0); end
    u_if.rx_ready = 1'b1;
    tick(10);
    checks++; if (got_q.size() - g0 !== 1) begin failures++; $display("FAIL b2b_drain_count: got %0d want 1", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== exp_held) begin failures++; $display("FAIL b2b_drain_data: got %h want %h", got_q[g0], exp_held); end
    end
    checks++; if (u_if.rx_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_clear: got %b want 0", u_if.rx_valid); end
  endtask

  task automatic test_glitch;
    int v0 = vld_cycles;
    bit seen_busy = 0;
    int release_at = -1;
    rx_input = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      if (i == 100) rx_input = 1'b1;
      tick(1);
      if (u_if.rx_busy === 1'b1) seen_busy = 1;
      if (seen_busy && u_if.rx_busy === 1'b0 && release_at < 0) release_at = i;
    end
    checks++; if (!seen_busy) begin failures++; $display("FAIL glitch_busy_seen: got 0 want 1"); end
    checks++; if (release_at < 0 || release_at >= 230) begin failures++; $display("FAIL glitch_release: got cycle %0d want <230", release_at); end
    checks++; if (vld_cycles - v0 !== 0) begin failures++; $display("FAIL glitch_valid: got %0d want 0", vld_cycles - v0); end
  endtask

  task automatic test_frame_err;
    int g0 = got_q.size();
    int v0 = vld_cycles;
    int e0 = err_cycles;
    send_frame(8'hA5, BIT_T, 1'b0);
    tick(2000);
    checks++; if (u_if.rx_busy !== 1'b1) begin failures++; $display("FAIL ferr_break_busy: got %b want 1", u_if.rx_busy); end
    checks++; if (err_cycles - e0 !== 1) begin failures++; $display("FAIL ferr_pulse: got %0d want 1", err_cycles - e0); end
    checks++; if (vld_cycles - v0 !== 0) begin failures++; $display("FAIL ferr_valid: got %0d want 0", vld_cycles - v0); end
    rx_input = 1'b1;
    tick(BIT_T);
    checks++; if (u_if.rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_recover_busy: got %b want 0", u_if.rx_busy); end
    send_frame(8'h3C, BIT_T, 1'b1);
    tick(20);
    checks++; if (got_q.size() - g0 !== 1) begin failures++; $display("FAIL ferr_next_count: got %0d want 1", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== 8'h3C) begin failures++; $display("FAIL ferr_next_data: got %h want 3c", got_q[g0]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int g0;
    int e0;
    // Start bit and bits 0..3 of 0xFF, then half of bit 4
    rx_input = 1'b0;
    tick(BIT_T);
    rx_input = 1'b1;
    tick(4 * BIT_T + BIT_T / 2);
    checks++; if (u_if.rx_busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before: got %b want 1", u_if.rx_busy); end
    rx_rst_n = 1'b0;
    #2;
    checks++; if (u_if.rx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_data: got %h want 00", u_if.rx_data); end
    checks++; if (u_if.rx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", u_if.rx_valid); end
    checks++; if (u_if.rx_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", u_if.rx_busy); end
    checks++; if (u_if.rx_frame_err !== 1'b0 || u_if.rx_overrun !== 1'b0) begin
      failures++; $display("FAIL rst_mid_pulses: got ferr=%b ovr=%b want 0 0", u_if.rx_frame_err, u_if.rx_overrun);
    end
    tick(100);
    rx_rst_n = 1'b1;
    tick(4 * BIT_T);
    g0 = got_q.size();
    e0 = err_cycles;
    send_frame(8'h0F, BIT_T, 1'b1);
    tick(20);
    checks++; if (got_q.size() - g0 !== 1) begin failures++; $display("FAIL rst_next_count: got %0d want 1", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== 8'h0F) begin failures++; $display("FAIL rst_next_data: got %h want 0f", got_q[g0]); end
    end
    checks++; if (u_if.rx_data !== 8'h0F) begin failures++; $display("FAIL rst_next_rx_data: got %h want 0f", u_if.rx_data); end
    checks++; if (err_cycles - e0 !== 0) begin failures++; $display("FAIL rst_next_ferr: got %0d want 0", err_cycles - e0); end
  endtask

  task automatic test_baud_tolerance;
    int periods[2] = '{425, 443};
    foreach (periods[k]) begin
      int g0 = got_q.size();
      send_frame(8'h55, periods[k], 1'b1);
      tick(20);
      checks++; if (got_q.size() - g0 !== 1) begin failures++; $display("FAIL baud%0d_count: got %0d want 1", periods[k], got_q.size() - g0); end
      else begin
        checks++; if (got_q[g0] !== 8'h55) begin failures++; $display("FAIL baud%0d_data: got %h want 55", periods[k], got_q[g0]); end
      end
    end
  endtask

  task automatic test_random;
    int g0 = got_q.size();
    exp_q.delete();
    for (int n = 0; n < 3; n++) begin
      logic [7:0] b = 8'($urandom_range(0, 255));
      int per = $urandom_range(426, 442);
      exp_q.push_back(b);
      send_frame(b, per, 1'b1);
      tick($urandom_range(1, 300));
    end
    checks++; if (got_q.size() - g0 !== exp_q.size()) begin
      failures++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++; if (got_q[g0 + i] !== exp_q[i]) begin failures++; $display("FAIL rand_data%0d: got %h want %h", i, got_q[g0 + i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
